seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the bus datapath, the successor to the 32-bit combinational `alu`. It keeps the same 12-bit one-hot operation select and the double-width result that splits into HI:LO. It generalises the operand width to `BITS` and adds a start/busy/done handshake. Multiply uses radix-2 Booth and divide uses a sequential non-restoring divider, so the block closes timing at any width. It sits between the Y register/bus (operands) and the Z register (result).

---
 rtl/seq_alu.sv | 203 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, radix-2 Booth multiply,
// non-restoring divide, with a start/busy/done handshake.
module seq_alu #(
  parameter int BITS = 32,
  parameter int SHW  = $clog2(BITS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [11:0]       ctrl_signal,
  input  logic [BITS-1:0]   X,
  input  logic [BITS-1:0]   Y,
  output logic [2*BITS-1:0] OpResult,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W2 = 2 * BITS;
  localparam logic [SHW:0] CNT_N = (SHW+1)'(BITS);
  localparam logic [SHW:0] CNT_1 = (SHW+1)'(1);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, DFIX, DONE
  } state_t;

  state_t          state;
  logic [SHW:0]    cnt;
  logic [BITS:0]   acc;
  logic [BITS:0]   m;
  logic [BITS-1:0] q;
  logic            q_1;
  logic            neg_q;
  logic            neg_r;

  logic            one_hot;
  logic [SHW-1:0]  sh;
  logic [W2-1:0]   dbl;
  logic [W2-1:0]   ror_w;
  logic [W2-1:0]   rol_w;
  logic [BITS-1:0] add_r;
  logic [BITS-1:0] sub_r;
  logic [BITS-1:0] neg_v;
  logic [BITS-1:0] x_mag;
  logic [BITS-1:0] y_mag;
  logic [W2-1:0]   sc_res;

  assign one_hot = (ctrl_signal != '0) &&
    ((ctrl_signal & (ctrl_signal - 12'd1)) == '0);
  assign sh    = Y[SHW-1:0];
  assign dbl   = {X, X};
  assign ror_w = dbl >> sh;
  assign rol_w = dbl << sh;
  assign add_r = X + Y;
  assign sub_r = X - Y;
  assign neg_v = -X;
  assign x_mag = X[BITS-1] ? -X : X;
  assign y_mag = Y[BITS-1] ? -Y : Y;

  always_comb begin
    sc_res = '0;
    if (one_hot) begin
      unique case (1'b1)
        ctrl_signal[0]:
          sc_res = {{BITS{add_r[BITS-1]}}, add_r};
        ctrl_signal[1]:
          sc_res = {{BITS{sub_r[BITS-1]}}, sub_r};
        ctrl_signal[2],
        ctrl_signal[3]:
          sc_res = '0;
        ctrl_signal[4]:
          sc_res = {{BITS{1'b0}}, X >> sh};
        ctrl_signal[5]:
          sc_res = {{BITS{1'b0}}, X << sh};
        ctrl_signal[6]:
          sc_res = {{BITS{1'b0}}, ror_w[BITS-1:0]};
        ctrl_signal[7]:
          sc_res = {{BITS{1'b0}}, rol_w[W2-1:BITS]};
        ctrl_signal[8]:
          sc_res = {{BITS{1'b0}}, X & Y};
        ctrl_signal[9]:
          sc_res = {{BITS{1'b0}}, X | Y};
        ctrl_signal[10]:
          sc_res = {{BITS{neg_v[BITS-1]}}, neg_v};
        ctrl_signal[11]:
          sc_res = {{BITS{1'b0}}, ~X};
        default:
          sc_res = '0;
      endcase
    end
  end

  // Booth step: acc is one bit wider so -M of the most negative
  // multiplicand cannot overflow.
  logic [BITS:0]   mul_sum;
  logic [W2+1:0]   mul_nx;

  always_comb begin
    mul_sum = acc;
    case ({q[0], q_1})
      2'b01:   mul_sum = acc + m;
      2'b10:   mul_sum = acc - m;
      default: mul_sum = acc;
    endcase
  end

  assign mul_nx = {mul_sum[BITS], mul_sum, q};

  logic [BITS:0]   r_sh;
  logic [BITS:0]   r_nx;
  logic [BITS:0]   r_fix;
  logic [BITS-1:0] rem_v;
  logic [BITS-1:0] quo_v;

  assign r_sh  = {acc[BITS-1:0], q[BITS-1]};
  assign r_nx  = acc[BITS] ? r_sh + m : r_sh - m;
  assign r_fix = acc[BITS] ? acc + m : acc;
  assign rem_v = neg_r ? -r_fix[BITS-1:0]
                       : r_fix[BITS-1:0];
  assign quo_v = neg_q ? -q : q;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      OpResult <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      q        <= '0;
      q_1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!one_hot) begin
              OpResult <= '0;
              err      <= 1'b1;
              state    <= DONE;
            end else if (ctrl_signal[2]) begin
              acc   <= '0;
              q     <= X;
              q_1   <= 1'b0;
              m     <= {Y[BITS-1], Y};
              cnt   <= CNT_N;
              state <= MUL;
            end else if (ctrl_signal[3]) begin
              if (Y == '0) begin
                OpResult <= {X, {BITS{1'b1}}};
                err      <= 1'b1;
                state    <= DONE;
              end else begin
                acc   <= '0;
                q     <= x_mag;
                m     <= {1'b0, y_mag};
                neg_q <= X[BITS-1] ^ Y[BITS-1];
                neg_r <= X[BITS-1];
                cnt   <= CNT_N;
                state <= DIV;
              end
            end else begin
              OpResult <= sc_res;
              err      <= 1'b0;
              state    <= DONE;
            end
          end
        end
        MUL: begin
          {acc, q, q_1} <= mul_nx;
          cnt           <= cnt - CNT_1;
          if (cnt == CNT_1) begin
            OpResult <= mul_nx[W2:1];
            err      <= 1'b0;
            state    <= DONE;
          end
        end
        DIV: begin
          acc <= r_nx;
          q   <= {q[BITS-2:0], ~r_nx[BITS]};
          cnt <= cnt - CNT_1;
          if (cnt == CNT_1)
            state <= DFIX;
        end
        DFIX: begin
          OpResult <= {rem_v, quo_v};
          err      <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at BITS=32 and BITS=8.
// Latency, result, err and handshake checks.
module tb_seq_alu;

  localparam logic [11:0] ADD = 12'h001;
  localparam logic [11:0] SUB = 12'h002;
  localparam logic [11:0] MLT = 12'h004;
  localparam logic [11:0] DVD = 12'h008;
  localparam logic [11:0] SHR = 12'h010;
  localparam logic [11:0] SHL = 12'h020;
  localparam logic [11:0] ROR = 12'h040;
  localparam logic [11:0] ROL = 12'h080;
  localparam logic [11:0] AND = 12'h100;
  localparam logic [11:0] OR  = 12'h200;
  localparam logic [11:0] NEG = 12'h400;
  localparam logic [11:0] NOT = 12'h800;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [11:0] ctrl  = '0;
  logic [31:0] x     = '0;
  logic [31:0] y     = '0;
  logic [63:0] res;
  logic        busy, done, err;

  logic        start8 = 1'b0;
  logic [11:0] ctrl8  = '0;
  logic [7:0]  x8     = '0;
  logic [7:0]  y8     = '0;
  logic [15:0] res8;
  logic        busy8, done8, err8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  seq_alu #(.BITS(32)) dut (
    .clock(clock), .clear(clear),
    .start(start), .ctrl_signal(ctrl),
    .X(x), .Y(y), .OpResult(res),
    .busy(busy), .done(done), .err(err)
  );

  seq_alu #(.BITS(8)) dut8 (
    .clock(clock), .clear(clear),
    .start(start8), .ctrl_signal(ctrl8),
    .X(x8), .Y(y8), .OpResult(res8),
    .busy(busy8), .done(done8), .err(err8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic op32(input string tag,
                      input logic [11:0] c,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [63:0] exp,
                      input logic exp_err,
                      input int exp_lat);
    int n;
    @(negedge clock);
    ctrl = c; x = a; y = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    x = '1; y = '1;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(exp_lat));
    chk({tag, ".res"}, res, exp);
    chk({tag, ".err"}, 64'(err), 64'(exp_err));
    @(negedge clock);
    chk({tag, ".idle"}, 64'({busy, done}), 64'(0));
  endtask

  task automatic op8(input string tag,
                     input logic [11:0] c,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [15:0] exp,
                     input int exp_lat);
    int n;
    @(negedge clock);
    ctrl8 = c; x8 = a; y8 = b; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(exp_lat));
    chk({tag, ".res"}, 64'(res8), 64'(exp));
    chk({tag, ".err"}, 64'(err8), 64'(0));
    @(negedge clock);
  endtask

  initial begin
    int dones;
    int first;
    int second;
    logic [63:0] last;

    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.err",  64'(err),  64'(0));
    chk("rst.res",  res,       64'(0));

    op32("add", ADD, 32'd3, 32'd5, 64'd8, 1'b0, 1);
    op32("sub", SUB, 32'd10, 32'd15,
         64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1);
    op32("shr", SHR, 32'd16, 32'd2, 64'd4, 1'b0, 1);
    op32("shl", SHL, 32'd16, 32'd2, 64'd64, 1'b0, 1);
    op32("ror", ROR, 32'd16, 32'd2, 64'd4, 1'b0, 1);
    op32("rol", ROL, 32'd16, 32'd2, 64'd64, 1'b0, 1);
    op32("ror1", ROR, 32'd1, 32'd1,
         64'h0000_0000_8000_0000, 1'b0, 1);
    op32("rol0", ROL, 32'd16, 32'd32, 64'd16, 1'b0, 1);
    op32("and", AND, 32'hFFFF_FFFF, 32'd0, 64'd0, 1'b0, 1);
    op32("or", OR, 32'hFFFF_FFFF, 32'd0,
         64'h0000_0000_FFFF_FFFF, 1'b0, 1);
    op32("neg", NEG, 32'd5, 32'd0,
         64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1);
    op32("not", NOT, 32'd0, 32'd0,
         64'h0000_0000_FFFF_FFFF, 1'b0, 1);

    // clear in the middle of a multiply
    @(negedge clock);
    ctrl = MLT; x = 32'd15; y = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("mid.busy", 64'(busy), 64'(1));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr.busy", 64'(busy), 64'(0));
    chk("clr.res", res, 64'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("clr.nodone", 64'(dones), 64'(0));

    op32("mul_pp", MLT, 32'd15, 32'd5, 64'd75, 1'b0, 33);
    op32("mul_pn", MLT, 32'd15, 32'hFFFF_FFFB,
         64'hFFFF_FFFF_FFFF_FFB5, 1'b0, 33);
    op32("mul_nn", MLT, 32'hFFFF_FFF1, 32'hFFFF_FFFB,
         64'd75, 1'b0, 33);
    op32("mul_min", MLT, 32'h8000_0000, 32'h8000_0000,
         64'h4000_0000_0000_0000, 1'b0, 33);

    op32("div_pp", DVD, 32'd15, 32'd5,
         64'h0000_0000_0000_0003, 1'b0, 34);
    op32("div_np", DVD, 32'hFFFF_FFF1, 32'd5,
         64'h0000_0000_FFFF_FFFD, 1'b0, 34);
    op32("div_pn", DVD, 32'd17, 32'hFFFF_FFFB,
         64'h0000_0002_FFFF_FFFD, 1'b0, 34);
    op32("div_nr", DVD, 32'hFFFF_FFEF, 32'd5,
         64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 34);
    op32("div_min", DVD, 32'h8000_0000, 32'hFFFF_FFFF,
         64'h0000_0000_8000_0000, 1'b0, 34);

    op32("div0", DVD, 32'd7, 32'd0,
         64'h0000_0007_FFFF_FFFF, 1'b1, 1);
    op32("multihot", 12'b0000_0000_0011, 32'd3, 32'd5,
         64'd0, 1'b1, 1);
    op32("zerohot", 12'd0, 32'd3, 32'd5,
         64'd0, 1'b1, 1);

    // start held high: one accept per 34 cycles
    @(negedge clock);
    ctrl = MLT; x = 32'd3; y = 32'd7; start = 1'b1;
    dones = 0; first = 0; second = 0;
    for (int i = 1; i <= 102; i++) begin
      @(negedge clock);
      if (done) begin
        dones++;
        if (dones == 1) first = i;
        if (dones == 2) second = i;
        last = res;
      end
    end
    start = 1'b0;
    chk("hold.count", 64'(dones), 64'(3));
    chk("hold.first", 64'(first), 64'(33));
    chk("hold.gap", 64'(second - first), 64'(34));
    chk("hold.res", last, 64'd21);
    repeat (40) @(negedge clock);

    // start pulse while busy is ignored
    @(negedge clock);
    ctrl = MLT; x = 32'd2; y = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    ctrl = ADD; x = 32'd1; y = 32'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    dones = 0;
    repeat (60) begin
      @(negedge clock);
      if (done) begin
        dones++;
        last = res;
      end
    end
    chk("busy.count", 64'(dones), 64'(1));
    chk("busy.res", last, 64'd6);

    op8("b8_add", ADD, 8'd3, 8'd5, 16'd8, 1);
    op8("b8_sub", SUB, 8'd10, 8'd15, 16'hFFFB, 1);
    op8("b8_shr", SHR, 8'd16, 8'd2, 16'd4, 1);
    op8("b8_shl", SHL, 8'd16, 8'd2, 16'd64, 1);
    op8("b8_ror", ROR, 8'd16, 8'd2, 16'd4, 1);
    op8("b8_rol", ROL, 8'd16, 8'd2, 16'd64, 1);
    op8("b8_rol0", ROL, 8'd16, 8'd8, 16'd16, 1);
    op8("b8_and", AND, 8'hFF, 8'd0, 16'd0, 1);
    op8("b8_or", OR, 8'hFF, 8'd0, 16'h00FF, 1);
    op8("b8_mpp", MLT, 8'd15, 8'd5, 16'd75, 9);
    op8("b8_mpn", MLT, 8'd15, 8'hFB, 16'hFFB5, 9);
    op8("b8_mnn", MLT, 8'hF1, 8'hFB, 16'd75, 9);
    op8("b8_min", MLT, 8'h80, 8'h80, 16'h4000, 9);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
